// File: rtl/apb_mailbox_pkg15.sv
// Shared constants and types for the APB mailbox responder.
package apb_mailbox_pkg15;

  // Register word offsets, compared against paddr[6:2]
  localparam logic [4:0] ADDR_CTRL    = 5'h00;
  localparam logic [4:0] ADDR_STATUS  = 5'h01;
  localparam logic [4:0] ADDR_TXDATA  = 5'h02;
  localparam logic [4:0] ADDR_SCRATCH = 5'h03;
  localparam logic [4:0] ADDR_OVFCLR  = 5'h04;

  // STATUS layout: count occupies [STATUS_COUNT_W-1:0]
  localparam int unsigned STATUS_COUNT_W   = 3;
  localparam int unsigned STATUS_FULL_BIT  = 3;
  localparam int unsigned STATUS_EMPTY_BIT = 4;
  localparam int unsigned STATUS_OVF_BIT   = 5;

  typedef enum logic {
    StIdle,
    StAccess
  } apb_state_e;

endpackage

// File: rtl/mbox_fifo15.sv
// Synchronous first-word-fall-through FIFO with push/pop/flush for the mailbox.
module mbox_fifo15 #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic             o_push_drop
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_count     = r_count;
  assign o_dout      = r_mem[r_rd_ptr];
  assign w_pop_ok    = i_pop & ~o_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign w_push_ok   = i_push & (~o_full | w_pop_ok);
  assign o_push_drop = i_push & o_full & ~w_pop_ok;

  // Storage, pointers and occupancy; flush overrides any push/pop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push_ok && w_pop_ok) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/apb_mailbox_slave15.sv
// APB responder with control/status registers, scratch word and a write mailbox FIFO.
import apb_mailbox_pkg15::*;

module apb_mailbox_slave15 #(
  parameter int unsigned WAIT_STATES   = 2,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [31:0] RESET_SCRATCH = 32'h0
) (
  input  logic        pclk15,
  input  logic        n_preset15,
  input  logic        psel15,
  input  logic        penable15,
  input  logic        pwrite15,
  input  logic [6:0]  paddr15,
  input  logic [31:0] pwdata15,
  output logic [31:0] prdata15,
  output logic        pready15,
  input  logic        fifo_pop15,
  output logic [31:0] fifo_dout15,
  output logic        fifo_empty15,
  output logic        irq15
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  apb_state_e    r_state;
  logic [3:0]    r_cnt;
  logic          r_ctrl_en;
  logic [31:0]   r_scratch;
  logic          r_ovf;

  logic [4:0]    w_word;
  logic          w_commit;
  logic          w_push_req;
  logic          w_flush;
  logic          w_ovf_clr;
  logic          w_fifo_full;
  logic          w_fifo_drop;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata_mux;
  logic          w_unused;

  assign w_word     = paddr15[6:2];
  assign w_unused   = ^paddr15[1:0];
  assign pready15   = (r_state == StAccess) && (r_cnt == 4'd0) && psel15 && penable15;
  assign w_commit   = pready15 & pwrite15;
  assign w_push_req = w_commit && (w_word == ADDR_TXDATA);
  // Flush is a one-cycle pulse straight into the FIFO, so CTRL[1] never holds state
  assign w_flush    = w_commit && (w_word == ADDR_CTRL) && pwdata15[1];
  assign w_ovf_clr  = w_commit && (w_word == ADDR_OVFCLR) && pwdata15[0];
  assign irq15      = r_ctrl_en & ~fifo_empty15;

  mbox_fifo15 #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clk       (pclk15),
    .i_rst_n     (n_preset15),
    .i_push      (w_push_req & r_ctrl_en),
    .i_din       (pwdata15),
    .i_pop       (fifo_pop15),
    .i_flush     (w_flush),
    .o_dout      (fifo_dout15),
    .o_full      (w_fifo_full),
    .o_empty     (fifo_empty15),
    .o_count     (w_count),
    .o_push_drop (w_fifo_drop)
  );

  // APB transfer FSM with wait-state counter; dropping psel abandons the access
  always_ff @(posedge pclk15 or negedge n_preset15) begin
    if (!n_preset15) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (psel15 && !penable15) begin
            r_state <= StAccess;
            r_cnt   <= 4'(WAIT_STATES);
          end
        end
        StAccess: begin
          if (!psel15 || pready15) begin
            r_state <= StIdle;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Software-visible registers, updated only on committed writes
  always_ff @(posedge pclk15 or negedge n_preset15) begin
    if (!n_preset15) begin
      r_ctrl_en <= 1'b0;
      r_scratch <= RESET_SCRATCH;
      r_ovf     <= 1'b0;
    end else begin
      if (w_commit && (w_word == ADDR_CTRL))    r_ctrl_en <= pwdata15[0];
      if (w_commit && (w_word == ADDR_SCRATCH)) r_scratch <= pwdata15;
      if (w_fifo_drop) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Read mux; prdata is only non-zero on the completing cycle of a read
  always_comb begin
    w_status                                = '0;
    w_status[STATUS_COUNT_W-1:0]            = STATUS_COUNT_W'(w_count);
    w_status[STATUS_FULL_BIT]               = w_fifo_full;
    w_status[STATUS_EMPTY_BIT]              = fifo_empty15;
    w_status[STATUS_OVF_BIT]                = r_ovf;
    w_rdata_mux = '0;
    case (w_word)
      ADDR_CTRL:    w_rdata_mux = {31'b0, r_ctrl_en};
      ADDR_STATUS:  w_rdata_mux = w_status;
      ADDR_SCRATCH: w_rdata_mux = r_scratch;
      default:      w_rdata_mux = '0;
    endcase
    prdata15 = (pready15 && !pwrite15) ? w_rdata_mux : '0;
  end

endmodule

// File: tb/tb_apb_mailbox_slave15.sv
// Directed bench for apb_mailbox_slave15 with WAIT_STATES=2.
module tb_apb_mailbox_slave15;

  logic        pclk15 = 1'b0;
  logic        n_preset15;
  logic        psel15;
  logic        penable15;
  logic        pwrite15;
  logic [6:0]  paddr15;
  logic [31:0] pwdata15;
  logic [31:0] prdata15;
  logic        pready15;
  logic        fifo_pop15;
  logic [31:0] fifo_dout15;
  logic        fifo_empty15;
  logic        irq15;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    bit          wr;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[21];

  apb_mailbox_slave15 #(
    .WAIT_STATES   (2),
    .FIFO_DEPTH    (4),
    .RESET_SCRATCH (32'h0)
  ) dut (
    .pclk15       (pclk15),
    .n_preset15   (n_preset15),
    .psel15       (psel15),
    .penable15    (penable15),
    .pwrite15     (pwrite15),
    .paddr15      (paddr15),
    .pwdata15     (pwdata15),
    .prdata15     (prdata15),
    .pready15     (pready15),
    .fifo_pop15   (fifo_pop15),
    .fifo_dout15  (fifo_dout15),
    .fifo_empty15 (fifo_empty15),
    .irq15        (irq15)
  );

  always #5 pclk15 = ~pclk15;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One APB transfer; pop is driven high during the completing cycle when requested
  task automatic xfer(input bit wr, input logic [6:0] a, input logic [31:0] d, input bit pop,
                      output logic [31:0] rd);
    int lat;
    @(posedge pclk15); #1;
    psel15 = 1'b1; penable15 = 1'b0; pwrite15 = wr; paddr15 = a; pwdata15 = d;
    @(posedge pclk15); #1;
    penable15 = 1'b1;
    lat = 0;
    rd  = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk15);
      lat++;
      if (pready15) begin
        rd = prdata15;
        fifo_pop15 = pop;
        break;
      end
    end
    check($sformatf("latency a=%02h", a), 32'(lat), 32'd3);
    @(posedge pclk15); #1;
    psel15 = 1'b0; penable15 = 1'b0; fifo_pop15 = 1'b0;
  endtask

  task automatic wr_reg(input logic [6:0] a, input logic [31:0] d);
    logic [31:0] rd;
    xfer(1'b1, a, d, 1'b0, rd);
  endtask

  task automatic rd_chk(input string name, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    xfer(1'b0, a, '0, 1'b0, rd);
    check(name, rd, exp);
  endtask

  task automatic pop_chk(input string name, input logic [31:0] exp);
    check(name, fifo_dout15, exp);
    @(posedge pclk15); #1;
    fifo_pop15 = 1'b1;
    @(posedge pclk15); #1;
    fifo_pop15 = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        rdy_seen;

    vecs[0]  = '{1'b1, 7'h0C, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 7'h0C, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b0, 7'h00, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 7'h04, 32'h0,        32'h10};
    vecs[4]  = '{1'b0, 7'h08, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 7'h7C, 32'hFFFFFFFF, 32'h0};
    vecs[6]  = '{1'b0, 7'h7C, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 7'h0C, 32'h0,        32'hDEADBEEF};
    vecs[8]  = '{1'b1, 7'h08, 32'h99,       32'h0};  // enable=0: dropped
    vecs[9]  = '{1'b0, 7'h04, 32'h0,        32'h10};
    vecs[10] = '{1'b1, 7'h00, 32'h1,        32'h0};
    vecs[11] = '{1'b0, 7'h00, 32'h0,        32'h1};
    vecs[12] = '{1'b1, 7'h08, 32'h11,       32'h0};
    vecs[13] = '{1'b1, 7'h08, 32'h22,       32'h0};
    vecs[14] = '{1'b1, 7'h08, 32'h33,       32'h0};
    vecs[15] = '{1'b1, 7'h08, 32'h44,       32'h0};
    vecs[16] = '{1'b0, 7'h04, 32'h0,        32'h0C};
    vecs[17] = '{1'b1, 7'h08, 32'h55,       32'h0};  // full: overflow
    vecs[18] = '{1'b0, 7'h04, 32'h0,        32'h2C};
    vecs[19] = '{1'b1, 7'h10, 32'h0,        32'h0};  // bit0=0: no clear
    vecs[20] = '{1'b0, 7'h04, 32'h0,        32'h2C};

    n_preset15 = 1'b0;
    psel15 = 1'b0; penable15 = 1'b0; pwrite15 = 1'b0;
    paddr15 = '0; pwdata15 = '0; fifo_pop15 = 1'b0;
    repeat (3) @(posedge pclk15);
    @(negedge pclk15);
    check("rst pready", 32'(pready15), 32'd0);
    check("rst prdata", prdata15, 32'h0);
    check("rst empty", 32'(fifo_empty15), 32'd1);
    check("rst irq", 32'(irq15), 32'd0);
    check("rst dout", fifo_dout15, 32'h0);
    n_preset15 = 1'b1;

    for (int i = 0; i < 21; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0, rd);
      if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp);
    end

    // Drain the full FIFO in order
    check("irq full", 32'(irq15), 32'd1);
    pop_chk("pop0", 32'h11);
    pop_chk("pop1", 32'h22);
    pop_chk("pop2", 32'h33);
    pop_chk("pop3", 32'h44);
    check("drained empty", 32'(fifo_empty15), 32'd1);
    check("drained irq", 32'(irq15), 32'd0);
    @(posedge pclk15); #1; fifo_pop15 = 1'b1;
    @(posedge pclk15); #1; fifo_pop15 = 1'b0;
    rd_chk("empty pop status", 7'h04, 32'h30);
    wr_reg(7'h10, 32'h1);
    rd_chk("ovfclr status", 7'h04, 32'h10);

    // Push into full FIFO with a simultaneous pop
    wr_reg(7'h08, 32'h11); wr_reg(7'h08, 32'h22);
    wr_reg(7'h08, 32'h33); wr_reg(7'h08, 32'h44);
    xfer(1'b1, 7'h08, 32'h66, 1'b1, rd);
    rd_chk("push+pop status", 7'h04, 32'h0C);
    pop_chk("pp pop0", 32'h22);
    pop_chk("pp pop1", 32'h33);
    pop_chk("pp pop2", 32'h44);
    pop_chk("pp pop3", 32'h66);

    // psel drops in the 2nd ACCESS cycle of a TXDATA write
    @(posedge pclk15); #1;
    psel15 = 1'b1; penable15 = 1'b0; pwrite15 = 1'b1; paddr15 = 7'h08; pwdata15 = 32'h77;
    @(posedge pclk15); #1;
    penable15 = 1'b1;
    @(negedge pclk15); rdy_seen = pready15;
    @(negedge pclk15); rdy_seen = rdy_seen | pready15;
    psel15 = 1'b0; penable15 = 1'b0;
    @(posedge pclk15); #1;
    check("abandon pready", 32'(rdy_seen), 32'd0);
    rd_chk("abandon status", 7'h04, 32'h10);

    // Flush keeps overflow; OVFCLR then clears it
    wr_reg(7'h08, 32'hA1); wr_reg(7'h08, 32'hA2); wr_reg(7'h08, 32'hA3);
    wr_reg(7'h08, 32'hA4); wr_reg(7'h08, 32'hA5);
    pop_chk("fl pop0", 32'hA1);
    pop_chk("fl pop1", 32'hA2);
    rd_chk("pre-flush status", 7'h04, 32'h22);
    wr_reg(7'h00, 32'h3);
    rd_chk("flush status", 7'h04, 32'h30);
    rd_chk("flush ctrl", 7'h00, 32'h1);
    check("flush irq", 32'(irq15), 32'd0);
    wr_reg(7'h10, 32'h1);
    rd_chk("flush ovfclr", 7'h04, 32'h10);

    // Reset during the completing ACCESS cycle of a SCRATCH write
    wr_reg(7'h08, 32'hB1);
    @(posedge pclk15); #1;
    psel15 = 1'b1; penable15 = 1'b0; pwrite15 = 1'b1; paddr15 = 7'h0C; pwdata15 = 32'h12345678;
    @(posedge pclk15); #1;
    penable15 = 1'b1;
    repeat (2) @(posedge pclk15);
    #1;
    check("pre-reset pready", 32'(pready15), 32'd1);
    n_preset15 = 1'b0;
    #1;
    check("reset pready", 32'(pready15), 32'd0);
    check("reset empty", 32'(fifo_empty15), 32'd1);
    check("reset irq", 32'(irq15), 32'd0);
    check("reset dout", fifo_dout15, 32'h0);
    @(negedge pclk15);
    psel15 = 1'b0; penable15 = 1'b0; pwrite15 = 1'b0;
    @(negedge pclk15);
    n_preset15 = 1'b1;
    rd_chk("reset scratch", 7'h0C, 32'h0);
    rd_chk("reset status", 7'h04, 32'h10);
    rd_chk("reset ctrl", 7'h00, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
